// File: rtl/regfile_op_sequencer.sv
// Single-client micro-sequencer for a 2R/1W register file: accepts one operation,
// reads both operands, computes the ALU result and writes it back over four cycles.
module regfile_op_sequencer #(
  parameter int WIDTH = 32,
  parameter int AW    = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [AW-1:0]    rs,
  input  logic [AW-1:0]    rt,
  input  logic [AW-1:0]    rd,
  input  logic [15:0]      imm,
  output logic             rf_we,
  output logic [AW-1:0]    rf_raddr1,
  output logic [AW-1:0]    rf_raddr2,
  output logic [AW-1:0]    rf_waddr,
  output logic [WIDTH-1:0] rf_wdata,
  input  logic [WIDTH-1:0] rf_rdata1,
  input  logic [WIDTH-1:0] rf_rdata2,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_EXEC  = 2'd2,
    ST_WRITE = 2'd3
  } state_t;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SLT = 3'b101;
  localparam logic [2:0] OP_SLL = 3'b110;
  localparam logic [2:0] OP_LI  = 3'b111;

  state_t           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic [AW-1:0]    rs_q, rs_d;
  logic [AW-1:0]    rt_q, rt_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic [15:0]      imm_q, imm_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] alu_res;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      op_q     <= '0;
      rs_q     <= '0;
      rt_q     <= '0;
      rd_q     <= '0;
      imm_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      rs_q     <= rs_d;
      rt_q     <= rt_d;
      rd_q     <= rd_d;
      imm_q    <= imm_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    alu_res = '0;
    unique case (op_q)
      OP_ADD: alu_res = a_q + b_q;
      OP_SUB: alu_res = a_q - b_q;
      OP_AND: alu_res = a_q & b_q;
      OP_OR:  alu_res = a_q | b_q;
      OP_XOR: alu_res = a_q ^ b_q;
      OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
      OP_SLL: alu_res = a_q << b_q[4:0];
      OP_LI:  alu_res = {{(WIDTH-16){1'b0}}, imm_q};
      default: alu_res = '0;
    endcase
  end

  // Handshake: a request transfers on a posedge where in_valid and in_ready are both
  // high; in_ready is high only in IDLE, and the requester holds its fields until then.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    rs_d      = rs_q;
    rt_d      = rt_q;
    rd_d      = rd_q;
    imm_d     = imm_q;
    a_d       = a_q;
    b_d       = b_q;
    result_d  = result_q;
    in_ready  = 1'b0;
    rf_we     = 1'b0;
    rf_raddr1 = '0;
    rf_raddr2 = '0;
    rf_waddr  = '0;
    rf_wdata  = '0;
    done      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          op_d    = op;
          rs_d    = rs;
          rt_d    = rt;
          rd_d    = rd;
          imm_d   = imm;
          state_d = ST_READ;
        end
      end
      ST_READ: begin
        rf_raddr1 = rs_q;
        rf_raddr2 = rt_q;
        a_d       = rf_rdata1;
        b_d       = rf_rdata2;
        state_d   = ST_EXEC;
      end
      ST_EXEC: begin
        result_d = alu_res;
        state_d  = ST_WRITE;
      end
      ST_WRITE: begin
        // A reset landing on the write edge must abort the write and suppress done.
        done     = ~rst;
        rf_we    = ~rst & (rd_q != '0);
        rf_waddr = rd_q;
        rf_wdata = result_q;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign result    = result_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_regfile_op_sequencer.sv
// Directed bench: regfile_op_sequencer driving a behavioural 32x32 register file.
module tb_regfile_op_sequencer;

  localparam int WIDTH = 32;
  localparam int AW    = 5;

  localparam logic [2:0] ADD = 3'b000;
  localparam logic [2:0] SUB = 3'b001;
  localparam logic [2:0] AND = 3'b010;
  localparam logic [2:0] OR  = 3'b011;
  localparam logic [2:0] XOR = 3'b100;
  localparam logic [2:0] SLT = 3'b101;
  localparam logic [2:0] SLL = 3'b110;
  localparam logic [2:0] LI  = 3'b111;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [AW-1:0]    rs, rt, rd;
  logic [15:0]      imm;
  logic             rf_we;
  logic [AW-1:0]    rf_raddr1, rf_raddr2, rf_waddr;
  logic [WIDTH-1:0] rf_wdata, rf_rdata1, rf_rdata2;
  logic             done;
  logic [WIDTH-1:0] result;
  logic [1:0]       state_dbg;

  int n_checks = 0;
  int n_errors = 0;

  // Observations from the most recent run_op
  logic [AW-1:0]    obs_raddr1, obs_raddr2, obs_waddr;
  logic [WIDTH-1:0] obs_wdata;
  logic             obs_we;
  int               obs_done_cnt, obs_we_cnt;

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural register file: r0 hard-wired to zero, combinational read
  logic [WIDTH-1:0] rf_mem [32];
  initial for (int i = 0; i < 32; i++) rf_mem[i] = '0;
  always @(posedge clk) if (rf_we && rf_waddr != '0) rf_mem[rf_waddr] <= rf_wdata;
  assign rf_rdata1 = (rf_raddr1 == '0) ? '0 : rf_mem[rf_raddr1];
  assign rf_rdata2 = (rf_raddr2 == '0) ? '0 : rf_mem[rf_raddr2];

  regfile_op_sequencer #(.WIDTH(WIDTH), .AW(AW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .rs(rs), .rt(rt), .rd(rd), .imm(imm),
    .rf_we(rf_we), .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .done(done), .result(result), .state_dbg(state_dbg)
  );

  // Driver: all calls start and end 1 time unit after a posedge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int k = 0;
    while (!in_ready && k < 16) begin
      step();
      k++;
    end
    if (!in_ready) begin
      n_checks++;
      n_errors++;
      $display("FAIL wait_ready: in_ready=%0b after %0d cycles, required 1", in_ready, k);
    end
  endtask

  task automatic run_op(input logic [2:0] o, input logic [AW-1:0] s, input logic [AW-1:0] t,
                        input logic [AW-1:0] d, input logic [15:0] im);
    wait_ready();
    op = o; rs = s; rt = t; rd = d; imm = im;
    in_valid = 1'b1;
    obs_done_cnt = 0;
    obs_we_cnt   = 0;
    step();
    in_valid = 1'b0;
    obs_raddr1 = rf_raddr1;
    obs_raddr2 = rf_raddr2;
    obs_done_cnt += int'(done);
    obs_we_cnt   += int'(rf_we);
    step();
    obs_done_cnt += int'(done);
    obs_we_cnt   += int'(rf_we);
    step();
    obs_we    = rf_we;
    obs_waddr = rf_waddr;
    obs_wdata = rf_wdata;
    obs_done_cnt += int'(done);
    obs_we_cnt   += int'(rf_we);
    step();
    obs_done_cnt += int'(done);
    obs_we_cnt   += int'(rf_we);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    n_checks++;
    if (in_ready !== 1'b1 || rf_we !== 1'b0 || done !== 1'b0 || state_dbg !== 2'd0) begin
      n_errors++;
      $display("FAIL reset_ctrl: ready=%b we=%b done=%b st=%0d, required 1 0 0 0",
               in_ready, rf_we, done, state_dbg);
    end
    n_checks++;
    if (rf_raddr1 !== '0 || rf_raddr2 !== '0 || rf_waddr !== '0 || rf_wdata !== '0) begin
      n_errors++;
      $display("FAIL reset_addr: ra1=%0d ra2=%0d wa=%0d wd=%h, required all 0",
               rf_raddr1, rf_raddr2, rf_waddr, rf_wdata);
    end
    n_checks++;
    if (result !== '0) begin
      n_errors++;
      $display("FAIL reset_result: got %h, required 0", result);
    end
  endtask

  task automatic test_li();
    run_op(LI, 5'd0, 5'd0, 5'd5, 16'd3);
    n_checks++;
    if (obs_we !== 1'b1 || obs_waddr !== 5'd5 || obs_wdata !== 32'd3) begin
      n_errors++;
      $display("FAIL li_write: we=%b wa=%0d wd=%h, required 1 5 3", obs_we, obs_waddr, obs_wdata);
    end
    n_checks++;
    if (obs_done_cnt !== 1) begin
      n_errors++;
      $display("FAIL li_done: %0d pulses, required 1", obs_done_cnt);
    end
    n_checks++;
    if (rf_mem[5] !== 32'd3 || result !== 32'd3) begin
      n_errors++;
      $display("FAIL li_r5: r5=%h result=%h, required 3 3", rf_mem[5], result);
    end
  endtask

  task automatic test_alu();
    run_op(LI, 5'd0, 5'd0, 5'd1, 16'd7);
    run_op(LI, 5'd0, 5'd0, 5'd2, 16'd5);
    run_op(ADD, 5'd1, 5'd2, 5'd3, 16'hffff);
    n_checks++;
    if (obs_raddr1 !== 5'd1 || obs_raddr2 !== 5'd2) begin
      n_errors++;
      $display("FAIL add_raddr: ra1=%0d ra2=%0d, required 1 2", obs_raddr1, obs_raddr2);
    end
    n_checks++;
    if (rf_mem[3] !== 32'd12) begin
      n_errors++;
      $display("FAIL add: r3=%h, required 0000000c", rf_mem[3]);
    end
    run_op(SUB, 5'd2, 5'd1, 5'd4, 16'h0);
    n_checks++;
    if (rf_mem[4] !== 32'hffff_fffe) begin
      n_errors++;
      $display("FAIL sub_wrap: r4=%h, required fffffffe", rf_mem[4]);
    end
    run_op(SLT, 5'd4, 5'd1, 5'd6, 16'h0);
    n_checks++;
    if (rf_mem[6] !== 32'd1) begin
      n_errors++;
      $display("FAIL slt_neg: r6=%h, required 1", rf_mem[6]);
    end
    run_op(SLT, 5'd1, 5'd4, 5'd6, 16'h0);
    n_checks++;
    if (rf_mem[6] !== 32'd0) begin
      n_errors++;
      $display("FAIL slt_pos: r6=%h, required 0", rf_mem[6]);
    end
    run_op(AND, 5'd1, 5'd2, 5'd8, 16'h0);
    n_checks++;
    if (rf_mem[8] !== 32'd5) begin
      n_errors++;
      $display("FAIL and: r8=%h, required 5", rf_mem[8]);
    end
    run_op(OR, 5'd1, 5'd2, 5'd8, 16'h0);
    n_checks++;
    if (rf_mem[8] !== 32'd7) begin
      n_errors++;
      $display("FAIL or: r8=%h, required 7", rf_mem[8]);
    end
    run_op(XOR, 5'd1, 5'd2, 5'd8, 16'h0);
    n_checks++;
    if (rf_mem[8] !== 32'd2) begin
      n_errors++;
      $display("FAIL xor: r8=%h, required 2", rf_mem[8]);
    end
    run_op(LI, 5'd0, 5'd0, 5'd11, 16'hbeef);
    n_checks++;
    if (rf_mem[11] !== 32'h0000_beef) begin
      n_errors++;
      $display("FAIL li_zext: r11=%h, required 0000beef", rf_mem[11]);
    end
  endtask

  task automatic test_sll();
    run_op(LI, 5'd0, 5'd0, 5'd1, 16'd1);
    run_op(LI, 5'd0, 5'd0, 5'd2, 16'd33);
    run_op(SLL, 5'd1, 5'd2, 5'd7, 16'h0);
    n_checks++;
    if (rf_mem[7] !== 32'd2) begin
      n_errors++;
      $display("FAIL sll: r7=%h, required 2", rf_mem[7]);
    end
  endtask

  task automatic test_r0();
    run_op(ADD, 5'd1, 5'd2, 5'd0, 16'h0);
    n_checks++;
    if (obs_done_cnt !== 1 || obs_we_cnt !== 0) begin
      n_errors++;
      $display("FAIL r0_ctrl: done=%0d we=%0d, required 1 0", obs_done_cnt, obs_we_cnt);
    end
    n_checks++;
    if (rf_mem[0] !== '0 || result !== 32'd34) begin
      n_errors++;
      $display("FAIL r0_data: r0=%h result=%h, required 0 22", rf_mem[0], result);
    end
  endtask

  task automatic test_back_to_back();
    logic [11:0] ready_mask;
    int          hs, done_cnt;
    logic        will_hs;
    run_op(LI, 5'd0, 5'd0, 5'd3, 16'd1);
    ready_mask = '0;
    hs = 0;
    done_cnt = 0;
    op = ADD; rs = 5'd3; rt = 5'd3; rd = 5'd3; imm = 16'h0;
    in_valid = 1'b1;
    for (int c = 0; c < 12; c++) begin
      ready_mask[c] = in_ready;
      done_cnt += int'(done);
      will_hs = in_ready & in_valid;
      step();
      if (will_hs) hs++;
      if (hs == 3) in_valid = 1'b0;
    end
    done_cnt += int'(done);
    n_checks++;
    if (ready_mask !== 12'b0001_0001_0001) begin
      n_errors++;
      $display("FAIL b2b_ready: mask=%b, required 000100010001", ready_mask);
    end
    n_checks++;
    if (done_cnt !== 3 || in_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL b2b_done: done=%0d ready=%b, required 3 1", done_cnt, in_ready);
    end
    n_checks++;
    if (rf_mem[3] !== 32'd8) begin
      n_errors++;
      $display("FAIL b2b_chain: r3=%h, required 8", rf_mem[3]);
    end
  endtask

  task automatic test_reset_abort();
    int stray;
    run_op(LI, 5'd0, 5'd0, 5'd9, 16'h55);
    wait_ready();
    op = ADD; rs = 5'd1; rt = 5'd2; rd = 5'd9; imm = 16'h0;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_checks++;
    if (in_ready !== 1'b1 || state_dbg !== 2'd0 || result !== '0) begin
      n_errors++;
      $display("FAIL exec_rst: ready=%b st=%0d result=%h, required 1 0 0",
               in_ready, state_dbg, result);
    end
    stray = 0;
    for (int c = 0; c < 4; c++) begin
      stray += int'(done) + int'(rf_we);
      step();
    end
    n_checks++;
    if (stray !== 0 || rf_mem[9] !== 32'h55) begin
      n_errors++;
      $display("FAIL exec_rst_nowrite: stray=%0d r9=%h, required 0 55", stray, rf_mem[9]);
    end
    // Reset arriving in the WRITE cycle itself
    op = ADD; rs = 5'd1; rt = 5'd2; rd = 5'd10; imm = 16'h0;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    rst = 1'b1;
    #1;
    n_checks++;
    if (rf_we !== 1'b0 || done !== 1'b0) begin
      n_errors++;
      $display("FAIL write_rst: we=%b done=%b, required 0 0", rf_we, done);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    n_checks++;
    if (rf_mem[10] !== '0 || in_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL write_rst_nowrite: r10=%h ready=%b, required 0 1", rf_mem[10], in_ready);
    end
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    op = '0; rs = '0; rt = '0; rd = '0; imm = '0;
    test_reset();
    test_li();
    test_alu();
    test_sll();
    test_r0();
    test_back_to_back();
    test_reset_abort();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
